adc_i2s_receiver: RTL and testbench

Receive-side counterpart of the DAC serial path. Deserialises the WM8731 ADC stream (AUD_ADCDAT framed by AUD_ADCLRCK, clocked by AUD_BCLK) into parallel left/right sample pairs in the CLOCK_50 domain. Delivers each pair over a valid/ready handshake to the mixer and capture logic. Codec pins are treated as asynchronous inputs and oversampled by CLOCK_50; AUD_BCLK and AUD_ADCLRCK are only observed, never driven.

---
 rtl/adc_i2s_receiver.sv | 193 +++++++++++++++++++
 tb/tb_adc_i2s_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_i2s_receiver.sv
// WM8731 ADC serial receiver: oversamples BCLK/LRCK/DAT in the CLOCK_50 domain,
// deserialises left/right words and presents each pair over a valid/ready handshake.
module adc_i2s_receiver #(
  parameter int DATA_WIDTH  = 24,
  parameter int I2S_DELAY   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        AUD_BCLK,
  input  logic        AUD_ADCLRCK,
  input  logic        AUD_ADCDAT,
  output logic [31:0] sample_left,
  output logic [31:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        clear_overrun
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  logic [2:0] pins;
  assign pins = {AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge CLOCK_50) begin
          if (reset) stage_q <= '0;
          else       stage_q <= pins;
        end
      end else begin : g_next
        always_ff @(posedge CLOCK_50) begin
          if (reset) stage_q <= '0;
          else       stage_q <= g_sync[gi-1].stage_q;
        end
      end
    end
  endgenerate

  logic bclk_s, lrck_s, dat_s;
  assign {bclk_s, lrck_s, dat_s} = g_sync[SYNC_STAGES-1].stage_q;

  state_t                state_q, state_d;
  logic                  bclk_prev_q;
  logic                  lrck_prev_q, lrck_prev_d;
  logic [5:0]            bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  commit_q, commit_d;
  logic [DATA_WIDTH-1:0] pair_left_q, pair_left_d;
  logic [DATA_WIDTH-1:0] pair_right_q, pair_right_d;
  logic [31:0]           sample_left_q, sample_left_d;
  logic [31:0]           sample_right_q, sample_right_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  overrun_set;
  logic                  bclk_rise;
  logic [IW-1:0]         bit_pos;

  assign bclk_rise = bclk_s & ~bclk_prev_q;

  function automatic logic [31:0] sext(input logic [DATA_WIDTH-1:0] v);
    logic [31:0] r;
    r = {32{v[DATA_WIDTH-1]}};
    r[DATA_WIDTH-1:0] = v;
    return r;
  endfunction

  // Capture uses the post-transition state so a left-justified MSB on the
  // boundary edge itself lands in the freshly cleared word.
  always_comb begin
    state_d      = state_q;
    lrck_prev_d  = lrck_prev_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    commit_d     = 1'b0;
    pair_left_d  = pair_left_q;
    pair_right_d = pair_right_q;
    bit_pos      = '0;
    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      if (lrck_s != lrck_prev_q) begin
        bit_idx_d = '0;
        case (state_q)
          SYNC: begin
            if (!lrck_s) begin
              state_d = LEFT;
              shift_d = '0;
            end
          end
          LEFT: begin
            if (lrck_s) begin
              left_hold_d = shift_q;
              shift_d     = '0;
              state_d     = RIGHT;
            end
          end
          RIGHT: begin
            if (!lrck_s) begin
              commit_d     = 1'b1;
              pair_left_d  = left_hold_q;
              pair_right_d = shift_q;
              shift_d      = '0;
              state_d      = LEFT;
            end
          end
          default: begin
            state_d = SYNC;
            shift_d = '0;
          end
        endcase
      end else if (bit_idx_q != 6'd63) begin
        bit_idx_d = bit_idx_q + 6'd1;
      end
      if ((state_d != SYNC) && (int'(bit_idx_d) >= I2S_DELAY) &&
          (int'(bit_idx_d) < I2S_DELAY + DATA_WIDTH)) begin
        bit_pos          = IW'(DATA_WIDTH - 1 - (int'(bit_idx_d) - I2S_DELAY));
        shift_d[bit_pos] = dat_s;
      end
    end
  end

  // A commit only replaces the held pair if it is empty or leaving this cycle.
  always_comb begin
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    overrun_set    = 1'b0;
    if (commit_q) begin
      if (!sample_valid_q || sample_ready) begin
        sample_left_d  = sext(pair_left_q);
        sample_right_d = sext(pair_right_q);
        sample_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end
    if (overrun_set)        overrun_d = 1'b1;
    else if (clear_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= SYNC;
      bclk_prev_q    <= 1'b0;
      lrck_prev_q    <= 1'b0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      left_hold_q    <= '0;
      commit_q       <= 1'b0;
      pair_left_q    <= '0;
      pair_right_q   <= '0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bclk_prev_q    <= bclk_s;
      lrck_prev_q    <= lrck_prev_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      left_hold_q    <= left_hold_d;
      commit_q       <= commit_d;
      pair_left_q    <= pair_left_d;
      pair_right_q   <= pair_right_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_i2s_receiver.sv
// Bench for adc_i2s_receiver: drives I2S and left-justified codec streams and
// scoreboards every accepted pair plus handshake, overrun and reset corners.
module tb_adc_i2s_receiver;

  localparam int DW   = 24;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        bclk     = 1'b0;
  logic        lrck     = 1'b1;
  logic        dat      = 1'b0;
  logic        ready    = 1'b0;
  logic        clr      = 1'b0;
  logic [31:0] l_a, r_a, l_b, r_b;
  logic        v_a, v_b, ov_a, ov_b;

  always #10 CLOCK_50 = ~CLOCK_50;

  adc_i2s_receiver #(.DATA_WIDTH(DW), .I2S_DELAY(1), .SYNC_STAGES(SS)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .sample_left(l_a), .sample_right(r_a), .sample_valid(v_a),
    .sample_ready(ready), .overrun(ov_a), .clear_overrun(clr)
  );

  adc_i2s_receiver #(.DATA_WIDTH(DW), .I2S_DELAY(0), .SYNC_STAGES(SS)) dut_lj (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .sample_left(l_b), .sample_right(r_b), .sample_valid(v_b),
    .sample_ready(ready), .overrun(ov_b), .clear_overrun(clr)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  vec_t  vecs [11];
  pair_t exp_q [$];
  int    n_cmp    = 0;
  int    n_err    = 0;
  int    cyc_cnt  = 0;
  int    rise_cyc = 0;
  bit    sel_lj   = 1'b0;
  logic  v_prev   = 1'b0;

  logic [31:0] m_l, m_r;
  logic        m_v, m_ov;
  assign m_l  = sel_lj ? l_b  : l_a;
  assign m_r  = sel_lj ? r_b  : r_a;
  assign m_v  = sel_lj ? v_b  : v_a;
  assign m_ov = sel_lj ? ov_b : ov_a;

  always @(posedge CLOCK_50) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard: every accepted pair is popped and compared; each valid rise is
  // timed from the most recent BCLK pin edge.
  always @(negedge CLOCK_50) begin
    if (m_v && !v_prev)
      check("latency", 32'(cyc_cnt - rise_cyc), 32'(SS + 2));
    if (m_v && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pair: got %h/%h, expected no pair", m_l, m_r);
      end else begin
        pair_t p;
        p = exp_q.pop_front();
        check("pair_left", m_l, p.l);
        check("pair_right", m_r, p.r);
      end
    end
    v_prev <= m_v;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic bit_low(input logic lr, input logic d);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (HALF) tick();
    bclk     = 1'b1;
    rise_cyc = cyc_cnt;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    bit_low(lr, d);
    repeat (HALF) tick();
  endtask

  function automatic logic slot_bit(input logic [23:0] w, input int dly, input int k);
    logic [4:0] idx;
    if (k >= dly && k < dly + DW) begin
      idx = 5'(DW - 1 - (k - dly));
      return w[idx];
    end
    return 1'b0;
  endfunction

  task automatic send_slot(input logic lr, input logic [23:0] w, input int dly,
                           input int first, input int nbits);
    for (int k = first; k < nbits; k++) send_bit(lr, slot_bit(w, dly, k));
  endtask

  task automatic push_exp(input logic [31:0] el, input logic [31:0] er);
    pair_t p;
    p.l = el;
    p.r = er;
    exp_q.push_back(p);
  endtask

  task automatic send_frame(input int i, input int dly, input bit push);
    if (push) push_exp(vecs[i].el, vecs[i].er);
    send_slot(1'b0, vecs[i].l, dly, 0, 32);
    send_slot(1'b1, vecs[i].r, dly, 0, 32);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d pairs still pending, expected 0", name, exp_q.size());
    end else begin
      $display("ok   %s: scoreboard empty", name);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_left"},    m_l, 32'h0);
    check({tag, "_right"},   m_r, 32'h0);
    check({tag, "_valid"},   {31'b0, m_v}, 32'h0);
    check({tag, "_overrun"}, {31'b0, m_ov}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{24'h7FFFFF, 24'h800001, 32'h007FFFFF, 32'hFF800001};
    vecs[1]  = '{24'h123456, 24'hFEDCBA, 32'h00123456, 32'hFFFEDCBA};
    vecs[2]  = '{24'h800000, 24'h000001, 32'hFF800000, 32'h00000001};
    vecs[3]  = '{24'h5A5A5A, 24'hA5A5A5, 32'h005A5A5A, 32'hFFA5A5A5};
    vecs[4]  = '{24'h000001, 24'hFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    vecs[5]  = '{24'h000010, 24'h000020, 32'h00000010, 32'h00000020};
    vecs[6]  = '{24'h000030, 24'h000040, 32'h00000030, 32'h00000040};
    vecs[7]  = '{24'h55AA55, 24'hAA55AA, 32'h0055AA55, 32'hFFAA55AA};
    vecs[8]  = '{24'h400000, 24'hC00000, 32'h00400000, 32'hFFC00000};
    vecs[9]  = '{24'h0F0F0F, 24'hF0F0F0, 32'h000F0F0F, 32'hFFF0F0F0};
    vecs[10] = '{24'hA5A5A5, 24'h3C3C3C, 32'hFFA5A5A5, 32'h003C3C3C};

    // Reset state, then clean I2S frames after a short idle right channel.
    repeat (5) tick();
    @(negedge CLOCK_50);
    check_reset_state("reset");
    tick();
    reset = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(i, 1, 1'b1);

    // Hold vecs[2]; pulse ready exactly on the posedge that loads vecs[3].
    ready = 1'b0;
    send_frame(3, 1, 1'b1);
    push_exp(vecs[4].el, vecs[4].er);
    bit_low(1'b0, slot_bit(vecs[4].l, 1, 0));
    repeat (SS + 1) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge CLOCK_50);
    check("swap_valid", {31'b0, m_v}, 32'h1);
    check("swap_left", m_l, vecs[3].el);
    check("swap_right", m_r, vecs[3].er);
    check("swap_overrun", {31'b0, m_ov}, 32'h0);
    repeat (HALF - SS - 2) tick();
    ready = 1'b1;
    send_slot(1'b0, vecs[4].l, 1, 1, 32);
    send_slot(1'b1, vecs[4].r, 1, 0, 32);

    // Overrun: vecs[5] held, vecs[6] dropped, then clear.
    push_exp(vecs[5].el, vecs[5].er);
    send_slot(1'b0, vecs[5].l, 1, 0, 32);
    ready = 1'b0;
    send_slot(1'b1, vecs[5].r, 1, 0, 32);
    send_frame(6, 1, 1'b0);
    send_frame(7, 1, 1'b1);
    @(negedge CLOCK_50);
    check("ovr_valid", {31'b0, m_v}, 32'h1);
    check("ovr_left", m_l, 32'h00000010);
    check("ovr_right", m_r, 32'h00000020);
    check("ovr_flag", {31'b0, m_ov}, 32'h1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge CLOCK_50);
    check("ovr_cleared", {31'b0, m_ov}, 32'h0);
    tick();
    ready = 1'b1;

    // Partial left word (commits vecs[7]), then reset mid-word.
    for (int k = 0; k < 12; k++) send_bit(1'b0, 1'b1);
    repeat (4) tick();
    check_drained("drain_i2s");
    reset = 1'b1;
    repeat (4) tick();
    @(negedge CLOCK_50);
    check_reset_state("midreset");
    tick();
    reset = 1'b0;

    // Resume mid-right channel: first pair out must be vecs[8].
    for (int k = 0; k < 16; k++) send_bit(1'b1, 1'b1);
    send_frame(8, 1, 1'b1);
    send_frame(9, 1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check_drained("drain_resume");

    // Left-justified instance: full frame then a 16-bit short left word.
    reset = 1'b1;
    repeat (4) tick();
    sel_lj = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
    send_frame(10, 0, 1'b1);
    push_exp(32'h00123400, 32'h000F0F0F);
    send_slot(1'b0, 24'h123400, 0, 0, 16);
    send_slot(1'b1, 24'h0F0F0F, 0, 0, 32);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check_drained("drain_lj");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
